// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for pointer crossings.
// Functions take zero-extended vectors so any pointer width up to GRAY_MAX_W works.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [GRAY_MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchronizer: STAGES flops in series, synchronous reset to 0.
module sync_chain #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_receiver.sv
// Receiving end of a Gray pointer crossing: synchronize, decode, check legality,
// and derive occupancy/empty/full against the local binary pointer.
module gray_ptr_receiver
  import gray_pkg::*;
#(
  parameter int unsigned PTR_WIDTH        = 4,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter bit          REMOTE_IS_WRITER = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PTR_WIDTH-1:0] gray_ptr_in,
  input  logic [PTR_WIDTH-1:0] local_bin_ptr,
  input  logic                 err_clr,
  output logic [PTR_WIDTH-1:0] remote_bin_ptr,
  output logic                 ptr_advance,
  output logic [PTR_WIDTH-1:0] advance_cnt,
  output logic [PTR_WIDTH-1:0] occupancy,
  output logic                 empty,
  output logic                 full,
  output logic                 hamming_err,
  output logic                 range_err
);

  localparam int unsigned          DEPTH   = 2 ** (PTR_WIDTH - 1);
  localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(DEPTH);

  logic [PTR_WIDTH-1:0] sync_gray;
  logic [PTR_WIDTH-1:0] prev_gray;
  logic [PTR_WIDTH-1:0] sync_bin;
  logic                 multi_bit_step;
  logic                 over_range;

  sync_chain #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gray_ptr_in),
    .q   (sync_gray)
  );

  always_comb begin
    sync_bin       = PTR_WIDTH'(gray2bin(GRAY_MAX_W'(sync_gray)));
    multi_bit_step = popcount(GRAY_MAX_W'(sync_gray ^ prev_gray)) > 1;
  end

  // Capture stage: decode, step size and change pulse all relative to the last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray      <= '0;
      remote_bin_ptr <= '0;
      advance_cnt    <= '0;
      ptr_advance    <= 1'b0;
    end else begin
      prev_gray      <= sync_gray;
      remote_bin_ptr <= sync_bin;
      advance_cnt    <= sync_bin - remote_bin_ptr;
      ptr_advance    <= (sync_gray != prev_gray);
    end
  end

  // Local pointer is used live so a local move never makes the flags optimistic.
  always_comb begin
    occupancy = '0;
    if (REMOTE_IS_WRITER) begin
      occupancy = remote_bin_ptr - local_bin_ptr;
    end else begin
      occupancy = local_bin_ptr - remote_bin_ptr;
    end
    empty      = (occupancy == '0);
    full       = (occupancy == DEPTH_P);
    over_range = (occupancy > DEPTH_P);
  end

  // Sticky error flags; a fresh set condition beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      hamming_err <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      if (multi_bit_step) begin
        hamming_err <= 1'b1;
      end else if (err_clr) begin
        hamming_err <= 1'b0;
      end
      if (over_range) begin
        range_err <= 1'b1;
      end else if (err_clr) begin
        range_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Directed, table-driven bench for gray_ptr_receiver at PTR_WIDTH=4, SYNC_STAGES=2.
module tb_gray_ptr_receiver;

  logic       clk;
  logic       rst;
  logic [3:0] gray_ptr_in;
  logic [3:0] local_bin_ptr;
  logic       err_clr;
  logic [3:0] remote_bin_ptr;
  logic       ptr_advance;
  logic [3:0] advance_cnt;
  logic [3:0] occupancy;
  logic       empty;
  logic       full;
  logic       hamming_err;
  logic       range_err;

  int errors = 0;
  int checks = 0;

  gray_ptr_receiver #(
    .PTR_WIDTH        (4),
    .SYNC_STAGES      (2),
    .REMOTE_IS_WRITER (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gray_ptr_in    (gray_ptr_in),
    .local_bin_ptr  (local_bin_ptr),
    .err_clr        (err_clr),
    .remote_bin_ptr (remote_bin_ptr),
    .ptr_advance    (ptr_advance),
    .advance_cnt    (advance_cnt),
    .occupancy      (occupancy),
    .empty          (empty),
    .full           (full),
    .hamming_err    (hamming_err),
    .range_err      (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [3:0] loc;
    logic [3:0] remote;
    logic       adv;
    logic [3:0] cnt;
    logic [3:0] occ;
    logic       emp;
    logic       ful;
    logic       herr;
    logic       rerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] g, input logic [3:0] loc,
                              input logic [3:0] remote, input logic adv,
                              input logic [3:0] cnt, input logic [3:0] occ,
                              input logic emp, input logic ful);
    vec_t v;
    v.g = g; v.loc = loc; v.remote = remote; v.adv = adv; v.cnt = cnt;
    v.occ = occ; v.emp = emp; v.ful = ful; v.herr = 1'b0; v.rerr = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] act_v;
  logic [17:0] exp_v;

  initial begin
    // Increment 0..5, then walk legally to 8 (full), local catches up (empty),
    // walk to 15 with local=8, then local=14 and wrap 15->0.
    vecs.push_back(mk(4'b0000, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0001, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0011, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0010, 4'd0,  4'd0,  1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b0110, 4'd0,  4'd1,  1'b1, 4'd1, 4'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0111, 4'd0,  4'd2,  1'b1, 4'd1, 4'd2, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0111, 4'd0,  4'd3,  1'b1, 4'd1, 4'd3, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0111, 4'd0,  4'd4,  1'b1, 4'd1, 4'd4, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0111, 4'd0,  4'd5,  1'b1, 4'd1, 4'd5, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0111, 4'd0,  4'd5,  1'b0, 4'd0, 4'd5, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0101, 4'd0,  4'd5,  1'b0, 4'd0, 4'd5, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0100, 4'd0,  4'd5,  1'b0, 4'd0, 4'd5, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1100, 4'd0,  4'd5,  1'b0, 4'd0, 4'd5, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1100, 4'd0,  4'd6,  1'b1, 4'd1, 4'd6, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1100, 4'd0,  4'd7,  1'b1, 4'd1, 4'd7, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1100, 4'd0,  4'd8,  1'b1, 4'd1, 4'd8, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1100, 4'd0,  4'd8,  1'b0, 4'd0, 4'd8, 1'b0, 1'b1));
    vecs.push_back(mk(4'b1100, 4'd8,  4'd8,  1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b1101, 4'd8,  4'd8,  1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b1111, 4'd8,  4'd8,  1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b1110, 4'd8,  4'd8,  1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    vecs.push_back(mk(4'b1010, 4'd8,  4'd9,  1'b1, 4'd1, 4'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1011, 4'd8,  4'd10, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1001, 4'd8,  4'd11, 1'b1, 4'd1, 4'd3, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1000, 4'd8,  4'd12, 1'b1, 4'd1, 4'd4, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1000, 4'd8,  4'd13, 1'b1, 4'd1, 4'd5, 1'b0, 1'b0));
    vecs.push_back(mk(4'b1000, 4'd8,  4'd14, 1'b1, 4'd1, 4'd6, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'd14, 4'd15, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'd14, 4'd15, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'd14, 4'd15, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'd14, 4'd0,  1'b1, 4'd1, 4'd2, 1'b0, 1'b0));
    vecs.push_back(mk(4'b0000, 4'd14, 4'd0,  1'b0, 4'd0, 4'd2, 1'b0, 1'b0));

    // Reset, two cycles with inputs at zero
    rst = 1'b1; gray_ptr_in = '0; local_bin_ptr = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_remote", 32'(remote_bin_ptr), 32'd0);
    check("rst_occ",    32'(occupancy),      32'd0);
    check("rst_empty",  32'(empty),          32'd1);
    check("rst_full",   32'(full),           32'd0);
    check("rst_adv",    32'(ptr_advance),    32'd0);
    check("rst_herr",   32'(hamming_err),    32'd0);
    check("rst_rerr",   32'(range_err),      32'd0);

    // Table: fields packed {remote,adv,cnt,occ,empty,full,herr,rerr}
    for (int i = 0; i < vecs.size(); i++) begin
      gray_ptr_in   = vecs[i].g;
      local_bin_ptr = vecs[i].loc;
      #1;
      act_v = {remote_bin_ptr, ptr_advance, advance_cnt, occupancy, empty, full,
               hamming_err, range_err};
      exp_v = {vecs[i].remote, vecs[i].adv, vecs[i].cnt, vecs[i].occ, vecs[i].emp,
               vecs[i].ful, vecs[i].herr, vecs[i].rerr};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL vec%0d: got %05h expected %05h (remote,adv,cnt,occ,emp,full,herr,rerr)",
                 i, act_v, exp_v);
      end
      tick();
    end

    // Illegal two-bit jump 0000 -> 0011
    local_bin_ptr = 4'd0;
    gray_ptr_in   = 4'b0011;
    tick(); tick();
    #1;
    check("herr_before_capture", 32'(hamming_err), 32'd0);
    tick();
    check("herr_set",        32'(hamming_err),    32'd1);
    check("herr_remote",     32'(remote_bin_ptr), 32'd2);
    tick(); tick();
    check("herr_held",       32'(hamming_err),    32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("herr_cleared",    32'(hamming_err),    32'd0);

    // Jump again (0011 -> 0110) with err_clr on the capture edge
    gray_ptr_in = 4'b0110;
    tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("herr_set_wins",   32'(hamming_err),    32'd1);
    check("herr_remote2",    32'(remote_bin_ptr), 32'd4);
    tick();
    check("herr_set_held",   32'(hamming_err),    32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("herr_cleared2",   32'(hamming_err),    32'd0);

    // Range: remote 10 against local 0
    gray_ptr_in = 4'b1111;
    tick(); tick(); tick();
    check("rng_occ",         32'(occupancy),      32'd10);
    check("rng_full",        32'(full),           32'd0);
    check("rng_not_yet",     32'(range_err),      32'd0);
    tick();
    check("rng_set",         32'(range_err),      32'd1);
    err_clr = 1'b1;
    tick();
    check("rng_clr_blocked", 32'(range_err),      32'd1);
    local_bin_ptr = 4'd4;
    #1;
    check("rng_occ_legal",   32'(occupancy),      32'd6);
    tick();
    err_clr = 1'b0;
    check("rng_cleared",     32'(range_err),      32'd0);
    check("herr_cleared3",   32'(hamming_err),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
